// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared types and constants for the L2 arbiter.
//   state_e : arbiter FSM states
//   side_e  : requester identity (I-cache / D-side)
//   op_t    : captured L2 operation (read / write)
//   addr_t, line_t : default-width address and line types
package l2_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int LINE_W_DEF = 128;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [LINE_W_DEF-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

    typedef struct packed {
        logic rd;
        logic wr;
    } op_t;

endpackage

// File: rtl/l2_arb_pick.sv
// l2_arb_pick: combinational winner selection for the L2 arbiter.
//   i_req, d_req : pending requests from I-cache and D-side
//   last_grant   : side served most recently (only consulted when
//                  L2_ARB_ROUND_ROBIN_EN is defined)
//   grant_valid  : at least one side is requesting
//   grant_side   : winning side
// Configuration macro: L2_ARB_ROUND_ROBIN_EN (undefined -> fixed D priority).
module l2_arb_pick
    import l2_arb_pkg::*;
(
    input  logic  i_req,
    input  logic  d_req,
    input  side_e last_grant,
    output logic  grant_valid,
    output side_e grant_side
);

`ifndef L2_ARB_ROUND_ROBIN_EN
    // Fixed priority never looks at history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant_valid = i_req | d_req;
        grant_side  = SIDE_D;
        if (i_req && !d_req) begin
            grant_side = SIDE_I;
        end
`ifdef L2_ARB_ROUND_ROBIN_EN
        else if (i_req && d_req && (last_grant == SIDE_D)) begin
            // Tie: hand the grant to the side not served last.
            grant_side = SIDE_I;
        end
`endif
    end

endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: arbitrates I-cache and D-side line requests onto one shared L2.
//   clk, rst                       : clock, synchronous active-high reset
//   i_read, i_address              : I-cache read request (held until i_mem_resp)
//   i_mem_resp, i_rdata            : I-side completion pulse and line
//   d_read, d_write, d_address,
//   d_wdata                        : D-side request (held until d_mem_resp)
//   d_mem_resp, d_rdata            : D-side completion pulse and line
//   l2_read, l2_write, l2_address,
//   l2_wdata                       : registered request to the L2
//   l2_mem_resp, l2_rdata          : L2 completion pulse and read line
// Configuration macro: L2_ARB_ROUND_ROBIN_EN enables round-robin tie break
// using a last_grant register; default build uses fixed D priority.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_mem_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_mem_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_mem_resp,
    input  logic [LINE_W-1:0] l2_rdata
);

    state_e            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic  grant_valid;
    side_e grant_side;
    side_e last_grant;
    logic  capture;
    logic  serving;

    assign serving = (state_q == ST_SERVE_I) || (state_q == ST_SERVE_D);
    assign capture = (state_q == ST_IDLE) && grant_valid;

`ifdef L2_ARB_ROUND_ROBIN_EN
    side_e last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (capture) begin
            last_grant_d = grant_side;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SIDE_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = SIDE_I;
`endif

    l2_arb_pick u_pick (
        .i_req       (i_read),
        .d_req       (d_read | d_write),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_side  (grant_side)
    );

    // State register plus captured request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    if (grant_side == SIDE_D) state_d = ST_SERVE_D;
                    else                      state_d = ST_SERVE_I;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (l2_mem_resp) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture on grant; the op is cleared on completion so l2_read/l2_write
    // fall in DONE straight from the register, with no state decode.
    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (capture) begin
            if (grant_side == SIDE_D) begin
                // Write wins if the D side raises both strobes.
                op_d.wr = d_write;
                op_d.rd = d_read & ~d_write;
                addr_d  = d_address;
                wdata_d = d_wdata;
            end else begin
                op_d.rd = 1'b1;
                op_d.wr = 1'b0;
                addr_d  = i_address;
                wdata_d = '0;
            end
        end else if (serving && l2_mem_resp) begin
            op_d = '0;
        end
    end

    // Outputs. Responses are qualified by state so L2 pulses in IDLE/DONE
    // never reach either requester.
    always_comb begin
        l2_read    = op_q.rd;
        l2_write   = op_q.wr;
        l2_address = addr_q;
        l2_wdata   = wdata_q;
        i_mem_resp = (state_q == ST_SERVE_I) && l2_mem_resp;
        d_mem_resp = (state_q == ST_SERVE_D) && l2_mem_resp;
        i_rdata    = l2_rdata;
        d_rdata    = l2_rdata;
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed self-checking bench for l2_arbiter.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_l2_arbiter;
    import l2_arb_pkg::*;

    localparam int AW = 16;
    localparam int LW = 128;
    localparam logic [LW-1:0] LINE_AA = {16{8'hAA}};
    localparam logic [LW-1:0] LINE_55 = {16{8'h55}};
    localparam logic [LW-1:0] LINE_33 = {16{8'h33}};
    localparam logic [LW-1:0] LINE_C3 = {16{8'hC3}};

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic          i_mem_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read, d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic          d_mem_resp;
    logic [LW-1:0] d_rdata;
    logic          l2_read, l2_write;
    logic [AW-1:0] l2_address;
    logic [LW-1:0] l2_wdata;
    logic          l2_mem_resp;
    logic [LW-1:0] l2_rdata;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address),
        .i_mem_resp(i_mem_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_mem_resp(d_mem_resp), .d_rdata(d_rdata),
        .l2_read(l2_read), .l2_write(l2_write),
        .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_mem_resp(l2_mem_resp), .l2_rdata(l2_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; l2_mem_resp = 0; l2_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        l2_mem_resp = 1'b1;   // stray L2 pulse in IDLE must be ignored
        l2_rdata = LINE_C3;
        @(negedge clk);
        vecs++; if (l2_read !== 1'b0) begin errs++; $display("FAIL reset_l2_read got=%0b exp=0", l2_read); end
        vecs++; if (l2_write !== 1'b0) begin errs++; $display("FAIL reset_l2_write got=%0b exp=0", l2_write); end
        vecs++; if (i_mem_resp !== 1'b0) begin errs++; $display("FAIL reset_i_mem_resp got=%0b exp=0", i_mem_resp); end
        vecs++; if (d_mem_resp !== 1'b0) begin errs++; $display("FAIL reset_d_mem_resp got=%0b exp=0", d_mem_resp); end
        vecs++; if (l2_address !== '0) begin errs++; $display("FAIL reset_l2_address got=%h exp=0", l2_address); end
        vecs++; if (l2_wdata !== '0) begin errs++; $display("FAIL reset_l2_wdata got=%h exp=0", l2_wdata); end
        tick();
        l2_mem_resp = 1'b0;
        l2_rdata = '0;
    endtask

    task automatic test_i_read();
        int rd_cnt = 0, ip = 0, dp = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin i_read = 1; i_address = 16'h1230; end
            if (c == 4) begin l2_mem_resp = 1; l2_rdata = LINE_AA; end
            if (c == 5) begin l2_mem_resp = 0; l2_rdata = '0; i_read = 0; end
            @(negedge clk);
            if (l2_read === 1'b1) rd_cnt++;
            if (d_mem_resp === 1'b1) dp++;
            if (i_mem_resp === 1'b1) begin
                ip++;
                vecs++; if (i_rdata !== LINE_AA) begin errs++; $display("FAIL iread_rdata got=%h exp=%h", i_rdata, LINE_AA); end
            end
            if (c == 1) begin
                vecs++; if (l2_address !== 16'h1230) begin errs++; $display("FAIL iread_addr got=%h exp=1230", l2_address); end
            end
            tick();
        end
        vecs++; if (rd_cnt != 4) begin errs++; $display("FAIL iread_l2_read_cycles got=%0d exp=4", rd_cnt); end
        vecs++; if (ip != 1) begin errs++; $display("FAIL iread_i_resp_pulses got=%0d exp=1", ip); end
        vecs++; if (dp != 0) begin errs++; $display("FAIL iread_d_resp_pulses got=%0d exp=0", dp); end
    endtask

    task automatic test_d_write();
        // c0 IDLE, c1 SERVE_D, c2 SERVE_D+resp, c3 DONE (I raised),
        // c4 IDLE, c5 SERVE_I+resp, c6 DONE
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: begin d_write = 1; d_address = 16'h0040; d_wdata = LINE_55; end
                2: begin l2_mem_resp = 1; l2_rdata = LINE_33; end
                3: begin l2_mem_resp = 0; d_write = 0; i_read = 1; i_address = 16'h0300; end
                5: begin l2_mem_resp = 1; l2_rdata = LINE_C3; end
                6: begin l2_mem_resp = 0; i_read = 0; end
                default: ;
            endcase
            @(negedge clk);
            case (c)
                0: begin
                    vecs++; if (l2_write !== 1'b0) begin errs++; $display("FAIL dwr_idle_write got=%0b exp=0", l2_write); end
                end
                1: begin
                    vecs++; if (l2_write !== 1'b1) begin errs++; $display("FAIL dwr_l2_write got=%0b exp=1", l2_write); end
                    vecs++; if (l2_read !== 1'b0) begin errs++; $display("FAIL dwr_l2_read got=%0b exp=0", l2_read); end
                    vecs++; if (l2_address !== 16'h0040) begin errs++; $display("FAIL dwr_addr got=%h exp=0040", l2_address); end
                    vecs++; if (l2_wdata !== LINE_55) begin errs++; $display("FAIL dwr_wdata got=%h exp=%h", l2_wdata, LINE_55); end
                    vecs++; if (d_mem_resp !== 1'b0) begin errs++; $display("FAIL dwr_early_resp got=%0b exp=0", d_mem_resp); end
                end
                2: begin
                    vecs++; if (d_mem_resp !== 1'b1) begin errs++; $display("FAIL dwr_d_resp got=%0b exp=1", d_mem_resp); end
                    vecs++; if (i_mem_resp !== 1'b0) begin errs++; $display("FAIL dwr_i_resp got=%0b exp=0", i_mem_resp); end
                end
                3: begin
                    vecs++; if (l2_write !== 1'b0) begin errs++; $display("FAIL dwr_done_write got=%0b exp=0", l2_write); end
                    vecs++; if (d_mem_resp !== 1'b0) begin errs++; $display("FAIL dwr_done_resp got=%0b exp=0", d_mem_resp); end
                end
                4: begin
                    vecs++; if (l2_read !== 1'b0) begin errs++; $display("FAIL dwr_idle_after_done got=%0b exp=0", l2_read); end
                end
                5: begin
                    vecs++; if (l2_read !== 1'b1) begin errs++; $display("FAIL dwr_next_read got=%0b exp=1", l2_read); end
                    vecs++; if (l2_address !== 16'h0300) begin errs++; $display("FAIL dwr_next_addr got=%h exp=0300", l2_address); end
                    vecs++; if (i_mem_resp !== 1'b1) begin errs++; $display("FAIL dwr_next_resp got=%0b exp=1", i_mem_resp); end
                end
                default: begin
                    vecs++; if (l2_read !== 1'b0) begin errs++; $display("FAIL dwr_final_read got=%0b exp=0", l2_read); end
                end
            endcase
            tick();
        end
    endtask

    // Four rounds of IDLE / SERVE(+resp) / DONE with I held throughout.
    // dpat[r]: D requests in round r; exp_d[r]: D expected to win round r.
    task automatic test_tie(input string nm, input logic [3:0] dpat, input logic [3:0] exp_d);
        for (int r = 0; r < 4; r++) begin
            i_read = 1; i_address = 16'h1000;
            d_read = dpat[r]; d_address = 16'h2000;
            @(negedge clk);
            vecs++; if (l2_read !== 1'b0) begin errs++; $display("FAIL %s_r%0d_idle got=%0b exp=0", nm, r, l2_read); end
            tick();
            l2_mem_resp = 1; l2_rdata = LINE_33;
            @(negedge clk);
            vecs++; if (l2_address !== (exp_d[r] ? 16'h2000 : 16'h1000))
                begin errs++; $display("FAIL %s_r%0d_addr got=%h exp=%h", nm, r, l2_address, exp_d[r] ? 16'h2000 : 16'h1000); end
            vecs++; if (d_mem_resp !== exp_d[r]) begin errs++; $display("FAIL %s_r%0d_d_resp got=%0b exp=%0b", nm, r, d_mem_resp, exp_d[r]); end
            vecs++; if (i_mem_resp !== !exp_d[r]) begin errs++; $display("FAIL %s_r%0d_i_resp got=%0b exp=%0b", nm, r, i_mem_resp, !exp_d[r]); end
            tick();
            l2_mem_resp = 0; d_read = 0;
            if (r == 3) i_read = 0;
            @(negedge clk);
            vecs++; if (l2_read !== 1'b0) begin errs++; $display("FAIL %s_r%0d_done got=%0b exp=0", nm, r, l2_read); end
            tick();
        end
    endtask

    task automatic test_d_addr_hold();
        // Both strobes high: captured op must be a write.
        d_read = 1; d_write = 1; d_address = 16'h0100; d_wdata = LINE_33;
        tick();
        d_address = 16'hBEEF; d_wdata = LINE_C3;
        @(negedge clk);
        vecs++; if (l2_address !== 16'h0100) begin errs++; $display("FAIL hold_addr1 got=%h exp=0100", l2_address); end
        vecs++; if (l2_write !== 1'b1) begin errs++; $display("FAIL hold_rw_write got=%0b exp=1", l2_write); end
        vecs++; if (l2_read !== 1'b0) begin errs++; $display("FAIL hold_rw_read got=%0b exp=0", l2_read); end
        vecs++; if (l2_wdata !== LINE_33) begin errs++; $display("FAIL hold_wdata got=%h exp=%h", l2_wdata, LINE_33); end
        tick();
        d_read = 0;   // dropped mid-service; transaction still completes
        l2_mem_resp = 1;
        @(negedge clk);
        vecs++; if (l2_address !== 16'h0100) begin errs++; $display("FAIL hold_addr2 got=%h exp=0100", l2_address); end
        vecs++; if (d_mem_resp !== 1'b1) begin errs++; $display("FAIL hold_d_resp got=%0b exp=1", d_mem_resp); end
        tick();
        l2_mem_resp = 0; d_write = 0;
        @(negedge clk);
        vecs++; if (l2_write !== 1'b0) begin errs++; $display("FAIL hold_done_write got=%0b exp=0", l2_write); end
        tick();
    endtask

    task automatic test_rst_mid();
        int ip = 0;
        i_read = 1; i_address = 16'h0ABC;
        tick();
        @(negedge clk);
        vecs++; if (l2_read !== 1'b1) begin errs++; $display("FAIL rstmid_serving got=%0b exp=1", l2_read); end
        tick();
        rst = 1; i_read = 0;
        @(negedge clk);
        if (i_mem_resp === 1'b1) ip++;
        tick();
        rst = 0; l2_mem_resp = 1; l2_rdata = LINE_AA;
        @(negedge clk);
        if (i_mem_resp === 1'b1) ip++;
        vecs++; if (ip != 0) begin errs++; $display("FAIL rstmid_i_resp got=%0d exp=0", ip); end
        vecs++; if (d_mem_resp !== 1'b0) begin errs++; $display("FAIL rstmid_d_resp got=%0b exp=0", d_mem_resp); end
        vecs++; if (l2_read !== 1'b0) begin errs++; $display("FAIL rstmid_l2_read got=%0b exp=0", l2_read); end
        vecs++; if (l2_address !== '0) begin errs++; $display("FAIL rstmid_addr got=%h exp=0", l2_address); end
        tick();
        // Requester reissues after reset.
        l2_mem_resp = 0; i_read = 1;
        tick();
        l2_mem_resp = 1;
        @(negedge clk);
        vecs++; if (l2_read !== 1'b1) begin errs++; $display("FAIL rstmid_reissue_read got=%0b exp=1", l2_read); end
        vecs++; if (i_mem_resp !== 1'b1) begin errs++; $display("FAIL rstmid_reissue_resp got=%0b exp=1", i_mem_resp); end
        tick();
        l2_mem_resp = 0; i_read = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
`ifdef L2_ARB_ROUND_ROBIN_EN
        test_tie("tieA", 4'b0111, 4'b0101);
`else
        test_tie("tieA", 4'b0111, 4'b0111);
`endif
        test_tie("tieB", 4'b0101, 4'b0101);
        test_d_addr_hold();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout vecs=%0d", vecs);
        $fatal(1, "timeout");
    end

endmodule
